gcc_param: RTL and testbench
============================

Name: gcc_param

Overview:
- Parametrised weighted gravity-centre calculator, successor to the fixed-width GCC block.
- Accepts a stream of (Xi, Yi, Wi) points through a valid/ready handshake and accumulates weighted sums.
- A set closes on a point-count limit or an explicit IN_LAST; the block then returns Xc = ΣWiXi/ΣWi and Yc = ΣWiYi/ΣWi through a sequential divider.
- Sits in the same datapath position as GCC and keeps its CLK/RESET_/READY_ naming.

Parameters:
- DW, 8: coordinate width (Xi, Yi, Xc, Yc).
- WW, 8: weight width (Wi).
- NPTS, 4: maximum points per set, ≥ 2.
- Derived CW = clog2(NPTS+1).
- Derived AW = DW+WW+CW: numerator accumulator width.
- Derived SW = WW+CW: weight-sum width.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET_  in  1  synchronous reset, active-high; the name is kept for continuity with GCC, but the polarity is high.
- IN_VALID  in  1  point present on Xi/Yi/Wi.
- IN_READY  out  1  block can accept a point.
- IN_LAST  in  1  qualifies an accepted point as the last point of the set.
- Xi  in  DW  point X coordinate, unsigned.
- Yi  in  DW  point Y coordinate, unsigned.
- Wi  in  WW  point weight, unsigned.
- Xc  out  DW  result X, registered.
- Yc  out  DW  result Y, registered.
- READY_  out  1  one-cycle pulse: Xc/Yc/ZERO_W are valid and new.
- ZERO_W  out  1  the last set had ΣWi = 0.

Behaviour:
- Reset (RESET_=1 at an edge):
  - State goes to ACC; Sx, Sy, Sw and the point count are cleared.
  - Xc=0, Yc=0, READY_=0, ZERO_W=0, IN_READY=1 after that edge.
  - Reset overrides every other event, including mid-division; an aborted set never produces a READY_ pulse.
- Handshake: a point is accepted at an edge where IN_VALID=1 and IN_READY=1. IN_READY=1 only in ACC.
- State ACC, on each accepted point:
  - Sx += Wi*Xi (AW bits), Sy += Wi*Yi (AW bits), Sw += Wi (SW bits), cnt += 1.
  - None of these can overflow by construction.
  - If IN_LAST=1 or cnt reaches NPTS, the set closes at that edge and the state goes to DIV.
  - IN_LAST=1 with IN_VALID=0 is ignored.
- State DIV:
  - Two restoring dividers run in parallel, one quotient bit per cycle, DW iterations, MSB first.
  - The quotient is bounded to DW bits because a weighted mean is at most max(Xi).
  - IN_VALID is ignored here; no points are lost and none are counted.
  - After DW cycles in DIV, go to DONE.
- State DONE, lasting one cycle:
  - Xc/Yc/ZERO_W are loaded.
  - READY_=1 for exactly this cycle; READY_ rises DW edges after the closing edge.
  - Accumulators and count are cleared; next edge returns to ACC with IN_READY=1.
  - A point presented while in DONE is not accepted.
- Between pulses, Xc/Yc/ZERO_W hold their last values.
- Zero weight: if Sw=0 at set close, the dividers still run for DW cycles so latency is constant. At DONE, Xc=0, Yc=0, ZERO_W=1.
- ZERO_W=0 for any set with Sw≠0.
- Division uses truncation toward zero unless ROUND_EN is defined.
- Throughput: one set per (points + DW + 1) cycles minimum.

Optional Feature:
- Macro GCC_PARAM_ROUND_EN.
- When defined:
  - The numerators become Sx + (Sw>>1) and Sy + (Sw>>1) at set close, giving round-half-up to nearest.
  - The numerator registers are widened by 1 bit; the result remains ≤ max coordinate and fits DW.
- When not defined: truncating quotient, and no extra adder or register bit is present.
- Latency and handshake are identical in both builds.

Test Plan:
All scenarios use DW=8, WW=8, NPTS=4.
1. Points (10,20,1),(30,40,1),(50,60,1),(70,80,1), no IN_LAST -> IN_READY drops after the 4th accept; READY_ pulses 8 edges later; Xc=40, Yc=50, ZERO_W=0.
2. Points (0,0,3),(100,200,1) with IN_LAST on the 2nd -> early close; Xc=25, Yc=50; the next set starts with clean sums.
3. Points (0,0,1),(1,1,1) with IN_LAST -> Xc=Yc=0 without the macro; Xc=Yc=1 with GCC_PARAM_ROUND_EN.
4. Four points with weight 0 -> READY_ at the same latency; Xc=0, Yc=0, ZERO_W=1. Then the set (255,255,255)x4 -> Xc=255, Yc=255, ZERO_W=0.
5. IN_VALID held high with random data during DIV/DONE -> no extra accepts; the result of scenario 1 is unchanged.
6. RESET_=1 for one edge at the 3rd DIV cycle -> no READY_ pulse; Xc=Yc=0; IN_READY=1 on the following cycle; the next full set computes correctly.

Source files
------------

// File: rtl/gcc_param.sv
// gcc_param: parametrised weighted gravity-centre calculator.
//
// Points (Xi, Yi, Wi) are accepted through a valid/ready handshake and accumulated into
// Sx = sum(Wi*Xi), Sy = sum(Wi*Yi) and Sw = sum(Wi). A set closes on IN_LAST or when NPTS
// points have been taken. Two restoring dividers then produce Xc = Sx/Sw and Yc = Sy/Sw,
// one quotient bit per cycle, and the result is presented with a one-cycle READY_ pulse.
//
// Ports:
//   CLK       clock, rising edge
//   RESET_    synchronous reset, active HIGH (name kept from the fixed-width GCC block)
//   IN_VALID  point present on Xi/Yi/Wi
//   IN_READY  block can accept a point (accumulate state only)
//   IN_LAST   accepted point closes the set
//   Xi, Yi    point coordinates, DW bits unsigned
//   Wi        point weight, WW bits unsigned
//   Xc, Yc    registered result, held between pulses
//   READY_    one-cycle pulse: Xc/Yc/ZERO_W are new
//   ZERO_W    last set had Sw = 0 (Xc = Yc = 0 in that case)
//
// Optional build macro: GCC_PARAM_ROUND_EN adds Sw/2 to the numerators at set close,
// giving round-half-up instead of truncation. Latency and handshake are unchanged.
// DW must be at least 2.
module gcc_param #(
    parameter int unsigned DW   = 8,
    parameter int unsigned WW   = 8,
    parameter int unsigned NPTS = 4
) (
    input  logic          CLK,
    input  logic          RESET_,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic          IN_LAST,
    input  logic [DW-1:0] Xi,
    input  logic [DW-1:0] Yi,
    input  logic [WW-1:0] Wi,
    output logic [DW-1:0] Xc,
    output logic [DW-1:0] Yc,
    output logic          READY_,
    output logic          ZERO_W
);

    localparam int unsigned CW = $clog2(NPTS + 1);
    localparam int unsigned AW = DW + WW + CW;
    localparam int unsigned SW = WW + CW;
`ifdef GCC_PARAM_ROUND_EN
    localparam int unsigned NW = AW + 1;
`else
    localparam int unsigned NW = AW;
`endif
    // Partial-remainder width: numerator bits above the DW quotient bits.
    localparam int unsigned RW = NW - DW;
    localparam int unsigned IW = $clog2(DW);

    typedef enum logic [1:0] {StAcc, StDiv, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [SW-1:0] sw_q, sw_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [IW-1:0] it_q, it_d;
    logic [DW-1:0] xc_q, xc_d, yc_q, yc_d;
    logic          zw_q, zw_d;

    logic [DW+WW-1:0] px, py;
    logic [AW-1:0]    sx_acc, sy_acc;
    logic [SW-1:0]    sw_acc;
    logic [NW-1:0]    nx, ny;

    // One restoring-division step. The register holds {partial remainder, numerator bits
    // still to be consumed, quotient bits produced so far}; the remainder stays below the
    // divisor because the weighted mean never exceeds the largest coordinate.
    function automatic logic [NW-1:0] div_step(input logic [NW-1:0] d, input logic [SW-1:0] s);
        logic [RW:0]   trial;
        logic [RW:0]   s_ext;
        logic          ge;
        logic [RW-1:0] rem;
        trial = {d[NW-1:DW], d[DW-1]};
        s_ext = {{(RW + 1 - SW){1'b0}}, s};
        ge    = (trial >= s_ext);
        rem   = RW'(ge ? (trial - s_ext) : trial);
        return {rem, d[DW-2:0], ge};
    endfunction

    assign px     = {{DW{1'b0}}, Wi} * {{WW{1'b0}}, Xi};
    assign py     = {{DW{1'b0}}, Wi} * {{WW{1'b0}}, Yi};
    assign sx_acc = sx_q + {{CW{1'b0}}, px};
    assign sy_acc = sy_q + {{CW{1'b0}}, py};
    assign sw_acc = sw_q + {{CW{1'b0}}, Wi};

`ifdef GCC_PARAM_ROUND_EN
    assign nx = {1'b0, sx_acc} + NW'(sw_acc >> 1);
    assign ny = {1'b0, sy_acc} + NW'(sw_acc >> 1);
`else
    assign nx = sx_acc;
    assign ny = sy_acc;
`endif

    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        sw_d    = sw_q;
        cnt_d   = cnt_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        it_d    = it_q;
        xc_d    = xc_q;
        yc_d    = yc_q;
        zw_d    = zw_q;
        unique case (state_q)
            StAcc: begin
                if (IN_VALID) begin
                    sx_d  = sx_acc;
                    sy_d  = sy_acc;
                    sw_d  = sw_acc;
                    cnt_d = cnt_q + CW'(1);
                    if (IN_LAST || (cnt_q == CW'(NPTS - 1))) begin
                        state_d = StDiv;
                        it_d    = '0;
                        // First quotient bit is taken on the closing edge itself, so the
                        // remaining DW-1 bits fit the DW DIV cycles with one spare at the end.
                        dx_d    = div_step(nx, sw_acc);
                        dy_d    = div_step(ny, sw_acc);
                    end
                end
            end
            StDiv: begin
                it_d = it_q + IW'(1);
                if (it_q == IW'(DW - 1)) begin
                    state_d = StDone;
                    zw_d    = (sw_q == '0);
                    xc_d    = (sw_q == '0) ? '0 : dx_q[DW-1:0];
                    yc_d    = (sw_q == '0) ? '0 : dy_q[DW-1:0];
                end else begin
                    dx_d = div_step(dx_q, sw_q);
                    dy_d = div_step(dy_q, sw_q);
                end
            end
            StDone: begin
                state_d = StAcc;
                sx_d    = '0;
                sy_d    = '0;
                sw_d    = '0;
                cnt_d   = '0;
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET_) begin
            state_q <= StAcc;
            sx_q    <= '0;
            sy_q    <= '0;
            sw_q    <= '0;
            cnt_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            it_q    <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
            zw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            it_q    <= it_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            zw_q    <= zw_d;
        end
    end

    assign IN_READY = (state_q == StAcc);
    assign READY_   = (state_q == StDone);
    assign Xc       = xc_q;
    assign Yc       = yc_q;
    assign ZERO_W   = zw_q;

endmodule

// File: tb/tb_gcc_param.sv
module tb_gcc_param;

    localparam int DW   = 8;
    localparam int WW   = 8;
    localparam int NPTS = 4;
`ifdef GCC_PARAM_ROUND_EN
    localparam bit Round = 1'b1;
`else
    localparam bit Round = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          RESET_;
    logic          IN_VALID;
    logic          IN_READY;
    logic          IN_LAST;
    logic [DW-1:0] Xi, Yi;
    logic [WW-1:0] Wi;
    logic [DW-1:0] Xc, Yc;
    logic          READY_;
    logic          ZERO_W;

    int vec = 0;
    int err = 0;
    bit check_en = 1'b0;

    // Behavioural model: a set's result is the plain weighted mean, delivered after a
    // fixed busy window of DW+1 cycles following the closing edge.
    int m_wait = 0;
    int m_n    = 0;
    int m_sx   = 0, m_sy = 0, m_sw = 0;
    int p_x    = 0, p_y  = 0;
    bit p_zw   = 1'b0;
    int m_xc   = 0, m_yc = 0;
    bit m_zw   = 1'b0;

    gcc_param #(.DW(DW), .WW(WW), .NPTS(NPTS)) dut (
        .CLK     (clk),
        .RESET_  (RESET_),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .IN_LAST (IN_LAST),
        .Xi      (Xi),
        .Yi      (Yi),
        .Wi      (Wi),
        .Xc      (Xc),
        .Yc      (Yc),
        .READY_  (READY_),
        .ZERO_W  (ZERO_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (RESET_) begin
            m_wait = 0; m_n = 0; m_sx = 0; m_sy = 0; m_sw = 0;
            m_xc = 0; m_yc = 0; m_zw = 1'b0;
        end else if (m_wait == 0) begin
            if (IN_VALID) begin
                m_sx = m_sx + int'(Wi) * int'(Xi);
                m_sy = m_sy + int'(Wi) * int'(Yi);
                m_sw = m_sw + int'(Wi);
                m_n  = m_n + 1;
                if (IN_LAST || m_n == NPTS) begin
                    p_zw = (m_sw == 0);
                    p_x  = p_zw ? 0 : (m_sx + (Round ? m_sw / 2 : 0)) / m_sw;
                    p_y  = p_zw ? 0 : (m_sy + (Round ? m_sw / 2 : 0)) / m_sw;
                    m_wait = DW + 1;
                    m_n = 0; m_sx = 0; m_sy = 0; m_sw = 0;
                end
            end
        end else begin
            m_wait = m_wait - 1;
            if (m_wait == 1) begin
                m_xc = p_x; m_yc = p_y; m_zw = p_zw;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("in_ready", 32'(IN_READY), 32'(m_wait == 0));
            check("ready_pulse", 32'(READY_), 32'(m_wait == 1));
            check("xc", 32'(Xc), 32'(m_xc));
            check("yc", 32'(Yc), 32'(m_yc));
            check("zero_w", 32'(ZERO_W), 32'(m_zw));
        end
    end

    task automatic send_point(input int x, input int y, input int w, input bit last);
        int guard;
        Xi = DW'(x); Yi = DW'(y); Wi = WW'(w); IN_LAST = last; IN_VALID = 1'b1;
        guard = 0;
        while (!IN_READY && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        IN_VALID = 1'b0; IN_LAST = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        bit found;
        found = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (READY_ === 1'b1) begin
                found = 1'b1;
                lat = i;
            end
        end
        if (!found) check("ready_timeout", 32'(0), 32'(1));
    endtask

    task automatic expect_result(input string tag, input int lat, input int x, input int y,
                                 input bit zw);
        check({tag, "_latency"}, 32'(lat), 32'(DW + 1));
        check({tag, "_xc"}, 32'(Xc), 32'(x));
        check({tag, "_yc"}, 32'(Yc), 32'(y));
        check({tag, "_zero_w"}, 32'(ZERO_W), 32'(zw));
    endtask

    task automatic send_s1();
        send_point(10, 20, 1, 1'b0);
        send_point(30, 40, 1, 1'b0);
        send_point(50, 60, 1, 1'b0);
        send_point(70, 80, 1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;
        RESET_ = 1'b1; IN_VALID = 1'b0; IN_LAST = 1'b0; Xi = '0; Yi = '0; Wi = '0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        RESET_ = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(IN_READY), 32'(1));
        check("rst_ready", 32'(READY_), 32'(0));
        check("rst_xc", 32'(Xc), 32'(0));
        check("rst_yc", 32'(Yc), 32'(0));
        check("rst_zero_w", 32'(ZERO_W), 32'(0));
        @(posedge clk); #1;

        // 1: count-limited close
        send_s1();
        check("s1_in_ready_low", 32'(IN_READY), 32'(0));
        wait_ready(lat);
        expect_result("s1", lat, 40, 50, 1'b0);
        repeat (2) @(posedge clk); #1;

        // 2: early close on IN_LAST
        send_point(0, 0, 3, 1'b0);
        send_point(100, 200, 1, 1'b1);
        wait_ready(lat);
        expect_result("s2", lat, 25, 50, 1'b0);

        // 3: rounding-sensitive set
        send_point(0, 0, 1, 1'b0);
        send_point(1, 1, 1, 1'b1);
        wait_ready(lat);
        expect_result("s3", lat, Round ? 1 : 0, Round ? 1 : 0, 1'b0);

        // 4: zero total weight, then full-scale set
        for (int i = 0; i < 4; i++) send_point(17 * i + 3, 40 + i, 0, 1'b0);
        wait_ready(lat);
        expect_result("s4_zero", lat, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) send_point(255, 255, 255, 1'b0);
        wait_ready(lat);
        expect_result("s4_full", lat, 255, 255, 1'b0);
        @(posedge clk); #1;

        // 5: IN_VALID held with random data through DIV and DONE
        send_s1();
        for (int i = 0; i < DW + 1; i++) begin
            Xi = DW'($urandom_range(0, 255));
            Yi = DW'($urandom_range(0, 255));
            Wi = WW'($urandom_range(0, 255));
            IN_LAST = 1'($urandom_range(0, 1));
            IN_VALID = 1'b1;
            @(posedge clk); #1;
        end
        IN_VALID = 1'b0; IN_LAST = 1'b0;
        check("s5_in_ready", 32'(IN_READY), 32'(1));
        check("s5_xc", 32'(Xc), 32'(40));
        check("s5_yc", 32'(Yc), 32'(50));

        // 6: reset in the third DIV cycle aborts the set
        send_point(0, 0, 3, 1'b0);
        send_point(100, 200, 1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        RESET_ = 1'b1;
        @(posedge clk); #1;
        RESET_ = 1'b0;
        check("s6_in_ready", 32'(IN_READY), 32'(1));
        check("s6_xc", 32'(Xc), 32'(0));
        check("s6_yc", 32'(Yc), 32'(0));
        seen = 0;
        repeat (DW + 4) begin
            @(negedge clk);
            if (READY_ !== 1'b0) seen++;
        end
        check("s6_no_pulse", 32'(seen), 32'(0));
        @(posedge clk); #1;
        send_s1();
        wait_ready(lat);
        expect_result("s6_after", lat, 40, 50, 1'b0);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
